bin_to_bcd4: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment display stage. It accepts a 32-bit unsigned binary value on a start strobe. It clamps the value to the displayable range 0–9999 and converts it with an iterative shift-and-add-3 (double-dabble) engine. It then presents four registered BCD digits, so the display stage only multiplexes digits and needs no divide or modulo logic.

---
 rtl/bin_to_bcd4_if.sv | 22 ++
 rtl/bin_to_bcd4.sv | 104 ++++++++++
 tb/tb_bin_to_bcd4.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd4_if.sv
// bin_to_bcd4 request/result bundle.
// master drives val/start; slave returns busy/done/bcd/ovf.
interface bin_to_bcd4_if #(
  parameter int IN_W = 32
);
  logic [IN_W-1:0] val;
  logic            start;
  logic            busy;
  logic            done;
  logic [15:0]     bcd;
  logic            ovf;

  modport master (
    output val, start,
    input  busy, done, bcd, ovf
  );

  modport slave (
    input  val, start,
    output busy, done, bcd, ovf
  );
endinterface

// File: rtl/bin_to_bcd4.sv
// Clamp-to-9999 double-dabble binary-to-BCD converter.
// Ports: clk, rst_n (async low), bus (slave: val/start in, busy/done/bcd/ovf out).
module bin_to_bcd4 #(
  parameter int IN_W    = 32,
  parameter int MAX_VAL = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  bin_to_bcd4_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [IN_W-1:0] MAX_W  = IN_W'(MAX_VAL);
  localparam logic [13:0]     MAX_14 = 14'(MAX_VAL);

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        over;
  logic        busy_d;
  logic        done_d;
  logic        busy_q;
  logic        done_q;
  logic [13:0] sh_q;
  logic [15:0] scr_q;
  logic [15:0] scr_adj;
  logic [3:0]  cnt_q;
  logic        pend_q;
  logic [15:0] bcd_q;
  logic        ovf_q;

  assign over = bus.val > MAX_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == 4'd13) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // busy lingers through the cycle after DONE so it
  // overlaps the done pulse.
  always_comb begin
    accept = (state_q == S_IDLE) && bus.start;
    done_d = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < 4; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (accept) begin
        sh_q   <= over ? MAX_14 : bus.val[13:0];
        scr_q  <= '0;
        pend_q <= over;
        cnt_q  <= '0;
      end else if (state_q == S_SHIFT) begin
        {scr_q, sh_q} <= {scr_adj[14:0], sh_q, 1'b0};
        cnt_q         <= cnt_q + 4'd1;
      end
      if (state_q == S_DONE) begin
        bcd_q <= scr_q;
        ovf_q <= pend_q;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd4.sv
// Randomized self-checking bench for bin_to_bcd4.
// Reference model: clamp then decimal digits by divide/modulo.
module tb_bin_to_bcd4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bin_to_bcd4_if #(.IN_W(32)) bus ();

  bin_to_bcd4 #(.IN_W(32), .MAX_VAL(9999)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ref_conv(input logic [31:0] v);
    int unsigned c;
    logic [15:0] d;
    c = (v > 32'd9999) ? 9999 : v;
    d[15:12] = 4'((c / 1000) % 10);
    d[11:8]  = 4'((c / 100) % 10);
    d[7:4]   = 4'((c / 10) % 10);
    d[3:0]   = 4'(c % 10);
    return {v > 32'd9999, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then count edges until done.
  task automatic convert(input logic [31:0] v, output logic [15:0] b,
                         output logic o, output int lat);
    bus.val   = v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    b = bus.bcd;
    o = bus.ovf;
  endtask

  task automatic test_reset();
    logic [15:0] b;
    int          lat;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.val   = 32'd7;
    #12;
    n_checks++;
    if ({bus.busy, bus.done, bus.ovf, bus.bcd} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state got b=%b d=%b o=%b bcd=%h want all 0",
               bus.busy, bus.done, bus.ovf, bus.bcd);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    b = bus.bcd;
    n_checks++;
    if (lat !== 15 || b !== 16'h0007) begin
      n_fail++;
      $display("FAIL reset_release got lat=%0d bcd=%h want 15 0007", lat, b);
    end
    tick();
  endtask

  task automatic test_nominal();
    logic [1:0] obs[17];
    bus.val   = 32'd1234;
    bus.start = 1'b1;
    tick();
    obs[0]    = {bus.busy, bus.done};
    bus.start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      obs[i] = {bus.busy, bus.done};
    end
    for (int i = 0; i <= 16; i++) begin
      logic [1:0] exp_bd;
      exp_bd = {i <= 15, i == 15};
      n_checks++;
      if (obs[i] !== exp_bd) begin
        n_fail++;
        $display("FAIL nominal_timing edge k+%0d got busy,done=%b want %b",
                 i, obs[i], exp_bd);
      end
    end
    n_checks++;
    if (bus.bcd !== 16'h1234 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_value got %h/%b want 1234/0", bus.bcd, bus.ovf);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] vals[6];
    logic [15:0] b;
    logic        o;
    int          lat;
    vals = '{32'd0, 32'd9999, 32'd10, 32'd10000, 32'hFFFF_FFFF, 32'd42};
    foreach (vals[i]) begin
      logic [16:0] e;
      e = ref_conv(vals[i]);
      convert(vals[i], b, o, lat);
      n_checks++;
      if (lat !== 15 || {o, b} !== e) begin
        n_fail++;
        $display("FAIL boundary val=%0d got lat=%0d ovf=%b bcd=%h want 15 %b %h",
                 vals[i], lat, o, b, e[16], e[15:0]);
      end
      tick();
    end
  endtask

  task automatic test_collision();
    int n_done;
    int first;
    bus.val   = 32'd5678;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_done    = 0;
    first     = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        bus.start = 1'b1;
        bus.val   = 32'd1111;
      end
      tick();
      if (i == 5) bus.start = 1'b0;
      if (bus.done) begin
        n_done++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (n_done !== 1 || first !== 15 || bus.bcd !== 16'h5678) begin
      n_fail++;
      $display("FAIL collision got dones=%0d at=%0d bcd=%h want 1 15 5678",
               n_done, first, bus.bcd);
    end
  endtask

  task automatic test_back_to_back();
    int          at[$];
    logic [15:0] seen[$];
    bus.val   = 32'd1111;
    bus.start = 1'b1;
    tick();
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (bus.done) begin
        at.push_back(i);
        seen.push_back(bus.bcd);
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (at.size() !== 3) begin
      n_fail++;
      $display("FAIL hold_count got %0d dones want 3", at.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_checks++;
        if (at[j] !== 15 + 16 * j || seen[j] !== 16'h1111) begin
          n_fail++;
          $display("FAIL hold_pulse%0d got at=%0d bcd=%h want %0d 1111",
                   j, at[j], seen[j], 15 + 16 * j);
        end
      end
    end
    for (int i = 0; i < 20; i++) tick();
  endtask

  task automatic test_reset_mid();
    logic [15:0] b;
    logic        o;
    int          lat;
    int          n_done;
    convert(32'd10000, b, o, lat);
    tick();
    bus.val   = 32'd4321;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.ovf, bus.bcd} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid got b=%b d=%b o=%b bcd=%h want all 0",
               bus.busy, bus.done, bus.ovf, bus.bcd);
    end
    tick();
    tick();
    rst_n  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    n_checks++;
    if (n_done !== 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_abort got dones=%0d busy=%b want 0 0",
               n_done, bus.busy);
    end
    convert(32'd4321, b, o, lat);
    n_checks++;
    if (lat !== 15 || b !== 16'h4321 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_redo got lat=%0d bcd=%h ovf=%b want 15 4321 0",
               lat, b, o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] b;
    logic        o;
    int          lat;
    for (int i = 0; i < 1800; i++) begin
      logic [31:0] v;
      logic [16:0] e;
      if (i % 8 == 7) v = $urandom;
      else            v = $urandom_range(0, 9999);
      e = ref_conv(v);
      convert(v, b, o, lat);
      n_checks++;
      if (lat !== 15 || {o, b} !== e) begin
        n_fail++;
        $display("FAIL random val=%0d got lat=%0d ovf=%b bcd=%h want 15 %b %h",
                 v, lat, o, b, e[16], e[15:0]);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.val   = '0;
    test_reset();
    test_nominal();
    test_boundaries();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
